// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Purpose  : Pipeline ID stage with register file, decoder, load-use hazard
//            detection and the ID/EX pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           i_code,
  input  logic [ADR_WIDTH-1:0]  i_pc,
  input  logic                  i_valid,
  input  logic                  i_flush,
  input  logic                  wb_en,
  input  logic [4:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  o_stall,
  output logic                  o_valid,
  output logic                  o_illegal,
  output logic [DATA_WIDTH-1:0] o_rs_data,
  output logic [DATA_WIDTH-1:0] o_rt_data,
  output logic [DATA_WIDTH-1:0] o_imme,
  output logic [4:0]            o_rs,
  output logic [4:0]            o_rt,
  output logic [4:0]            o_rd,
  output logic [ADR_WIDTH-1:0]  o_pc,
  output logic [ADR_WIDTH-1:0]  o_jump_addr,
  output logic                  o_reg_write,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic                  o_alu_src,
  output logic                  o_reg_dst,
  output logic                  o_mem_to_reg,
  output logic                  o_branch,
  output logic                  o_jump,
  output logic [2:0]            o_alu_op
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_J     = 6'h02;

  localparam logic [5:0] c_FN_ADD = 6'h20;
  localparam logic [5:0] c_FN_SUB = 6'h22;
  localparam logic [5:0] c_FN_AND = 6'h24;
  localparam logic [5:0] c_FN_OR  = 6'h25;
  localparam logic [5:0] c_FN_SLT = 6'h2A;

  localparam logic [2:0] c_ALU_ADD = 3'd0;
  localparam logic [2:0] c_ALU_SUB = 3'd1;
  localparam logic [2:0] c_ALU_AND = 3'd2;
  localparam logic [2:0] c_ALU_OR  = 3'd3;
  localparam logic [2:0] c_ALU_SLT = 3'd4;

  logic [DATA_WIDTH-1:0] r_regs [32];

  logic [5:0]            w_op;
  logic [5:0]            w_funct;
  logic [4:0]            w_rs;
  logic [4:0]            w_rt;
  logic [DATA_WIDTH-1:0] w_rs_data;
  logic [DATA_WIDTH-1:0] w_rt_data;
  logic [DATA_WIDTH-1:0] w_imme;
  logic [ADR_WIDTH-1:0]  w_jump_addr;
  logic                  w_legal;
  logic                  w_uses_rt;
  logic                  w_reg_write;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic                  w_alu_src;
  logic                  w_reg_dst;
  logic                  w_mem_to_reg;
  logic                  w_branch;
  logic                  w_jump;
  logic [2:0]            w_alu_op;
  logic                  w_stall;
  logic                  w_accept;
  logic                  w_issue;

  assign w_op    = i_code[31:26];
  assign w_rs    = i_code[25:21];
  assign w_rt    = i_code[20:16];
  assign w_funct = i_code[5:0];
  assign w_imme  = {{(DATA_WIDTH-16){i_code[15]}}, i_code[15:0]};
  assign w_jump_addr = {i_pc[ADR_WIDTH-1:28], i_code[25:0], 2'b00};

  // Read ports forward a same-cycle write-back so the ID stage never sees stale data.
  assign w_rs_data = (w_rs == 5'd0) ? '0 :
                     (wb_en && (wb_addr == w_rs)) ? wb_data : r_regs[w_rs];
  assign w_rt_data = (w_rt == 5'd0) ? '0 :
                     (wb_en && (wb_addr == w_rt)) ? wb_data : r_regs[w_rt];

  always_comb begin
    w_legal      = 1'b1;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_alu_src    = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_alu_op     = c_ALU_ADD;
    case (w_op)
      c_OP_RTYPE: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        case (w_funct)
          c_FN_ADD: w_alu_op = c_ALU_ADD;
          c_FN_SUB: w_alu_op = c_ALU_SUB;
          c_FN_AND: w_alu_op = c_ALU_AND;
          c_FN_OR:  w_alu_op = c_ALU_OR;
          c_FN_SLT: w_alu_op = c_ALU_SLT;
          default:  w_legal  = 1'b0;
        endcase
      end
      c_OP_LW: begin
        w_alu_src    = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
      end
      c_OP_SW: begin
        w_alu_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      c_OP_BEQ: begin
        w_alu_op = c_ALU_SUB;
        w_branch = 1'b1;
      end
      c_OP_ADDI: begin
        w_alu_src   = 1'b1;
        w_reg_write = 1'b1;
      end
      c_OP_J:  w_jump  = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  // rt is a true source operand only for R-type, sw and beq.
  assign w_uses_rt = (w_op == c_OP_RTYPE) || (w_op == c_OP_SW) || (w_op == c_OP_BEQ);

  assign w_stall = i_valid && !i_flush && o_valid && o_mem_read && (o_rt != 5'd0) &&
                   ((o_rt == w_rs) || (w_uses_rt && (o_rt == w_rt)));
  assign o_stall = w_stall;

  assign w_accept = i_valid && !i_flush && !w_stall;
  assign w_issue  = w_accept && w_legal;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid      <= 1'b0;
      o_illegal    <= 1'b0;
      o_rs_data    <= '0;
      o_rt_data    <= '0;
      o_imme       <= '0;
      o_rs         <= '0;
      o_rt         <= '0;
      o_rd         <= '0;
      o_pc         <= '0;
      o_jump_addr  <= '0;
      o_reg_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_alu_src    <= 1'b0;
      o_reg_dst    <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_branch     <= 1'b0;
      o_jump       <= 1'b0;
      o_alu_op     <= '0;
    end else begin
      o_valid      <= w_issue;
      o_illegal    <= w_accept && !w_legal;
      o_rs_data    <= w_rs_data;
      o_rt_data    <= w_rt_data;
      o_imme       <= w_imme;
      o_rs         <= w_rs;
      o_rt         <= w_rt;
      o_rd         <= i_code[15:11];
      o_pc         <= i_pc;
      o_jump_addr  <= w_jump_addr;
      o_reg_write  <= w_issue && w_reg_write;
      o_mem_read   <= w_issue && w_mem_read;
      o_mem_write  <= w_issue && w_mem_write;
      o_alu_src    <= w_issue && w_alu_src;
      o_reg_dst    <= w_issue && w_reg_dst;
      o_mem_to_reg <= w_issue && w_mem_to_reg;
      o_branch     <= w_issue && w_branch;
      o_jump       <= w_issue && w_jump;
      o_alu_op     <= w_issue ? w_alu_op : 3'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module   : tb_decode_stage
// Purpose  : Randomized and directed scoreboard bench for decode_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage;

  localparam int c_DW = 3*32 + 15 + 2*32;

  typedef struct packed {
    logic [12:0]     ctl;
    logic [c_DW-1:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] i_code = '0;
  logic [31:0] i_pc = '0;
  logic        i_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        o_stall, o_valid, o_illegal;
  logic [31:0] o_rs_data, o_rt_data, o_imme, o_pc, o_jump_addr;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic        o_reg_write, o_mem_read, o_mem_write, o_alu_src;
  logic        o_reg_dst, o_mem_to_reg, o_branch, o_jump;
  logic [2:0]  o_alu_op;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  logic [31:0] m_regs [32];
  logic        m_prev_valid;
  logic        m_prev_load;
  logic [4:0]  m_prev_rt;

  decode_stage #(.DATA_WIDTH(32), .ADR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_code(i_code), .i_pc(i_pc), .i_valid(i_valid),
    .i_flush(i_flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .o_stall(o_stall), .o_valid(o_valid), .o_illegal(o_illegal),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imme(o_imme),
    .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_pc(o_pc), .o_jump_addr(o_jump_addr),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst), .o_mem_to_reg(o_mem_to_reg),
    .o_branch(o_branch), .o_jump(o_jump), .o_alu_op(o_alu_op)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] act_ctl();
    return {o_valid, o_illegal, o_reg_write, o_mem_read, o_mem_write, o_alu_src,
            o_reg_dst, o_mem_to_reg, o_branch, o_jump, o_alu_op};
  endfunction

  function automatic logic [c_DW-1:0] act_dat();
    return {o_rs_data, o_rt_data, o_imme, o_rs, o_rt, o_rd, o_pc, o_jump_addr};
  endfunction

  task automatic check(input string name, input logic [c_DW-1:0] act, input logic [c_DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: {legal, reg_write, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, branch, jump, alu_op}
  function automatic logic [11:0] ref_decode(input logic [31:0] code);
    logic [5:0] op;
    logic [5:0] fn;
    op = code[31:26];
    fn = code[5:0];
    if (op == 6'h00) begin
      if (fn == 6'h20) return {1'b1, 8'b1000_1000, 3'd0};
      if (fn == 6'h22) return {1'b1, 8'b1000_1000, 3'd1};
      if (fn == 6'h24) return {1'b1, 8'b1000_1000, 3'd2};
      if (fn == 6'h25) return {1'b1, 8'b1000_1000, 3'd3};
      if (fn == 6'h2A) return {1'b1, 8'b1000_1000, 3'd4};
      return '0;
    end
    if (op == 6'h23) return {1'b1, 8'b1101_0100, 3'd0};
    if (op == 6'h2B) return {1'b1, 8'b0011_0000, 3'd0};
    if (op == 6'h04) return {1'b1, 8'b0000_0010, 3'd1};
    if (op == 6'h08) return {1'b1, 8'b1001_0000, 3'd0};
    if (op == 6'h02) return {1'b1, 8'b0000_0001, 3'd0};
    return '0;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic step(input logic [31:0] code, input logic v, input logic f, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, output logic stalled);
    logic [11:0] d;
    logic [4:0]  rs, rt;
    logic        uses_rt, stl, accept, issue;
    logic [31:0] pc;
    exp_t        e;
    @(negedge clk);
    pc = $urandom;
    i_code = code; i_pc = pc; i_valid = v; i_flush = f;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    rs = code[25:21];
    rt = code[20:16];
    uses_rt = (code[31:26] == 6'h00) || (code[31:26] == 6'h2B) || (code[31:26] == 6'h04);
    stl = v && !f && m_prev_valid && m_prev_load && (m_prev_rt != 0) &&
          (m_prev_rt == rs || (uses_rt && m_prev_rt == rt));
    check("stall", {{(c_DW-1){1'b0}}, o_stall}, {{(c_DW-1){1'b0}}, stl});
    d = ref_decode(code);
    accept = v && !f && !stl;
    issue = accept && d[11];
    e.ctl = issue ? {1'b1, 1'b0, d[10:0]} : {1'b0, accept, 11'b0};
    e.dat = {ref_read(rs, we, wa, wd), ref_read(rt, we, wa, wd),
             {{16{code[15]}}, code[15:0]}, rs, rt, code[15:11], pc,
             {pc[31:28], code[25:0], 2'b00}};
    sb.push_back(e);
    @(posedge clk);
    if (we && wa != 0) m_regs[wa] = wd;
    m_prev_valid = issue;
    m_prev_load = issue && d[9];
    m_prev_rt = rt;
    stalled = stl;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_prev_valid = 1'b0;
    m_prev_load = 1'b0;
    m_prev_rt = '0;
  endtask

  // Monitor: one ID/EX slot is presented per cycle; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("ctl", {{(c_DW-13){1'b0}}, act_ctl()}, {{(c_DW-13){1'b0}}, e.ctl});
        if (e.ctl[12]) check("data", act_dat(), e.dat);
      end
    end
  end

  initial begin
    logic        s;
    logic [31:0] cur;
    logic [5:0]  ops [10];
    logic [5:0]  fns [6];
    logic [5:0]  op;
    int          guard;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02, 6'h3F, 6'h01, 6'h00, 6'h23};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21};
    model_reset();

    #12;
    check("reset_ctl", {{(c_DW-13){1'b0}}, act_ctl()}, '0);
    check("reset_dat", act_dat(), '0);
    check("reset_stall", {{(c_DW-1){1'b0}}, o_stall}, '0);
    @(negedge clk);
    rst = 1'b1;

    // Write-back then add r3,r5,r0 reading it.
    step(32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, s);
    step(32'h00A01820, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, s);
    // Load-use: add stalls once then issues.
    step(32'h8C220004, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, s);
    guard = 0;
    do begin
      step(32'h00422020, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, s);
      guard++;
    end while (s && guard < 4);
    check("stall_once", guard, 2);
    // Bypass r7, and writes to r0 are dropped.
    step(32'h00070820, 1'b1, 1'b0, 1'b1, 5'd7, 32'hDEAD, s);
    step(32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hBEEF, s);
    step(32'h00000820, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, s);
    // Flush overrides a load-use hazard.
    step(32'h8C220004, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, s);
    step(32'h00422020, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, s);
    // addi with negative immediate, then an undecodable opcode.
    step(32'h2001FFFF, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, s);
    step(32'hFC000000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, s);

    s = 1'b0;
    cur = '0;
    for (int n = 0; n < 400; n++) begin
      if (!s) begin
        op = ops[$urandom_range(0, 9)];
        if (op == 6'h00)
          cur = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'd0, fns[$urandom_range(0, 5)]};
        else if (op == 6'h02)
          cur = {op, 26'($urandom)};
        else
          cur = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      end
      step(cur, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
           1'($urandom), 5'($urandom_range(0, 7)), $urandom, s);
    end

    // Mid-cycle reset clears outputs and the register file without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    check("midrst_ctl", {{(c_DW-13){1'b0}}, act_ctl()}, '0);
    check("midrst_dat", act_dat(), '0);
    check("midrst_stall", {{(c_DW-1){1'b0}}, o_stall}, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int r = 1; r < 8; r++)
      step({6'h00, 5'(r), 5'(r), 5'd1, 5'd0, 6'h20}, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, s);

    @(posedge clk);
    #2;
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
